// File: rtl/float_mul_pipe_if.sv
// float_mul_pipe_if -- operand/result bundle between the accelerator
// sequencer and the binary32 multiplier pipeline.
//
// Signals:
//   run      start-of-run pulse from the accelerator
//   running  pipeline enable; registers advance only while high
//   in0      multiplicand, binary32
//   in1      multiplier, binary32
//   out0     product, binary32, three running-high edges after sampling
//
// Modports:
//   master   drives operands and enables, observes the product
//   slave    the multiplier itself
interface float_mul_pipe_if #(
    parameter int DATA_W = 32
);
    logic              run;
    logic              running;
    logic [DATA_W-1:0] in0;
    logic [DATA_W-1:0] in1;
    logic [31:0]       out0;

    modport master (
        output run,
        output running,
        output in0,
        output in1,
        input  out0
    );

    modport slave (
        input  run,
        input  running,
        input  in0,
        input  in1,
        output out0
    );
endinterface

// File: rtl/float_mul_pipe.sv
// float_mul_pipe -- 3-stage IEEE-754 binary32 multiplier feeding the float
// accumulator. Flush-to-zero on denormal inputs, truncating rounding, no
// denormal outputs. Stateless per element; run is accepted but unused.
//
// Ports:
//   clk   clock, all state on rising edge
//   rst   asynchronous active-high reset; clears every stage and out0
//   bus   float_mul_pipe_if.slave: run, running, in0, in1 in; out0 out
//
// Stages:
//   1  unpack: sign, biased exponent sum, mantissas with hidden bit, flags
//   2  48-bit mantissa product
//   3  normalize, range clamp, special-case select -> out0
module float_mul_pipe #(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    float_mul_pipe_if.slave   bus
);

    localparam logic [31:0] QNAN = 32'h7FC0_0000;

    // ------------------------------------------------------------------
    // Stage 1: unpack and classify
    // ------------------------------------------------------------------
    logic [7:0]  ea, eb;
    logic [22:0] fa, fb;
    logic        a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;

    assign ea = bus.in0[30:23];
    assign eb = bus.in1[30:23];
    assign fa = bus.in0[22:0];
    assign fb = bus.in1[22:0];

    // Exponent 0 covers both true zero and denormals: both flush to zero.
    assign a_zero = (ea == 8'h00);
    assign b_zero = (eb == 8'h00);
    assign a_inf  = (ea == 8'hFF) && (fa == 23'h0);
    assign b_inf  = (eb == 8'hFF) && (fb == 23'h0);
    assign a_nan  = (ea == 8'hFF) && (fa != 23'h0);
    assign b_nan  = (eb == 8'hFF) && (fb != 23'h0);

    logic              s1_sign_d, s1_nan_d, s1_inf_d, s1_zero_d;
    logic signed [9:0] s1_exp_d;
    logic [23:0]       s1_ma_d, s1_mb_d;

    assign s1_sign_d = bus.in0[31] ^ bus.in1[31];
    // Ten signed bits hold -127..+383 without wrap.
    assign s1_exp_d  = $signed({2'b00, ea}) + $signed({2'b00, eb}) - 10'sd127;
    assign s1_ma_d   = {1'b1, fa};
    assign s1_mb_d   = {1'b1, fb};
    // inf x zero is invalid and folds into the NaN flag.
    assign s1_nan_d  = a_nan | b_nan | (a_inf & b_zero) | (b_inf & a_zero);
    assign s1_inf_d  = a_inf | b_inf;
    assign s1_zero_d = a_zero | b_zero;

    logic              s1_sign_q, s1_nan_q, s1_inf_q, s1_zero_q;
    logic signed [9:0] s1_exp_q;
    logic [23:0]       s1_ma_q, s1_mb_q;

    // ------------------------------------------------------------------
    // Stage 2: mantissa product
    // ------------------------------------------------------------------
    logic [47:0]       s2_prod_d;
    assign s2_prod_d = s1_ma_q * s1_mb_q;

    logic              s2_sign_q, s2_nan_q, s2_inf_q, s2_zero_q;
    logic signed [9:0] s2_exp_q;
    logic [47:0]       s2_prod_q;

    // ------------------------------------------------------------------
    // Stage 3: normalize, clamp, special select
    // ------------------------------------------------------------------
    // Product of two [1,2) mantissas lies in [1,4); bit 47 set means [2,4)
    // and needs a one-place shift with exponent increment. Bits below the
    // kept 23 are simply dropped (truncation toward zero).
    logic signed [9:0] exp_n;
    logic [22:0]       mant_n;
    logic [31:0]       out0_d;

    assign exp_n  = s2_prod_q[47] ? (s2_exp_q + 10'sd1) : s2_exp_q;
    assign mant_n = s2_prod_q[47] ? s2_prod_q[46:24] : s2_prod_q[45:23];

    always_comb begin
        out0_d = {s2_sign_q, exp_n[7:0], mant_n};
        if (s2_nan_q) begin
            out0_d = QNAN;
        end else if (s2_inf_q) begin
            out0_d = {s2_sign_q, 8'hFF, 23'h0};
        end else if (s2_zero_q) begin
            out0_d = {s2_sign_q, 31'h0};
        end else if (exp_n >= 10'sd255) begin
            out0_d = {s2_sign_q, 8'hFF, 23'h0};
        end else if (exp_n <= 10'sd0) begin
            out0_d = {s2_sign_q, 31'h0};
        end
    end

    logic [31:0] out0_q;
    assign bus.out0 = out0_q;

    // ------------------------------------------------------------------
    // Pipeline registers: cleared by reset, frozen while running is low.
    // An all-zero stage 2 resolves to +0 at the output, so the pipe emits
    // exactly 32'h0 while refilling after reset.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_sign_q <= 1'b0;
            s1_nan_q  <= 1'b0;
            s1_inf_q  <= 1'b0;
            s1_zero_q <= 1'b0;
            s1_exp_q  <= '0;
            s1_ma_q   <= '0;
            s1_mb_q   <= '0;
            s2_sign_q <= 1'b0;
            s2_nan_q  <= 1'b0;
            s2_inf_q  <= 1'b0;
            s2_zero_q <= 1'b0;
            s2_exp_q  <= '0;
            s2_prod_q <= '0;
            out0_q    <= '0;
        end else if (bus.running) begin
            s1_sign_q <= s1_sign_d;
            s1_nan_q  <= s1_nan_d;
            s1_inf_q  <= s1_inf_d;
            s1_zero_q <= s1_zero_d;
            s1_exp_q  <= s1_exp_d;
            s1_ma_q   <= s1_ma_d;
            s1_mb_q   <= s1_mb_d;
            s2_sign_q <= s1_sign_q;
            s2_nan_q  <= s1_nan_q;
            s2_inf_q  <= s1_inf_q;
            s2_zero_q <= s1_zero_q;
            s2_exp_q  <= s1_exp_q;
            s2_prod_q <= s2_prod_d;
            out0_q    <= out0_d;
        end
    end

    // run carries no meaning for a per-element block; the low product bits
    // are discarded by truncation.
    logic [23:0] unused_bits;
    assign unused_bits = {bus.run, s2_prod_q[22:0]};

endmodule

// File: tb/tb_float_mul_pipe.sv
module tb_float_mul_pipe;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    float_mul_pipe_if #(.DATA_W(32)) bus ();

    float_mul_pipe #(.DATA_W(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] y;
    } vec_t;

    typedef struct {
        int          edge_n;
        int          tag;
        logic [31:0] y;
    } sb_t;

    localparam int NVEC = 14;
    vec_t        vecs [NVEC];
    sb_t         sb_q [$];
    int          edge_cnt = 0;
    int          n_checks = 0;
    int          n_fail   = 0;
    logic [31:0] cur_exp  = 32'h0;
    int          cur_tag  = -1;

    task automatic check_val(input string name, input int tag,
                             input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s tag=%0d out0=%08h expected=%08h", name, tag, got, want);
        end else begin
            $display("ok   %s tag=%0d out0=%08h", name, tag, got);
        end
    endtask

    // Expected out0 after each edge: the scoreboard head once it has aged
    // two further running edges past its sampling edge, else the held value.
    task automatic check_out(input string name);
        if (sb_q.size() > 0 && sb_q[0].edge_n + 2 == edge_cnt) begin
            cur_exp = sb_q[0].y;
            cur_tag = sb_q[0].tag;
            void'(sb_q.pop_front());
        end
        check_val(name, cur_tag, bus.out0, cur_exp);
    endtask

    task automatic step(input logic run_en, input logic run_p, input int tag,
                        input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] y, input string name);
        sb_t e;
        bus.running = run_en;
        bus.run     = run_p;
        bus.in0     = a;
        bus.in1     = b;
        @(posedge clk);
        #1;
        if (run_en && !rst) begin
            edge_cnt++;
            e.edge_n = edge_cnt;
            e.tag    = tag;
            e.y      = y;
            sb_q.push_back(e);
        end
        check_out(name);
    endtask

    initial begin
        vecs[0]  = '{32'h3F800000, 32'h3F800000, 32'h3F800000};
        vecs[1]  = '{32'h3FC00000, 32'hC0000000, 32'hC0400000};
        vecs[2]  = '{32'h3F800001, 32'h3F800001, 32'h3F800002};
        vecs[3]  = '{32'h3FFFFFFF, 32'h3FFFFFFF, 32'h407FFFFE};
        vecs[4]  = '{32'h7F000000, 32'h7F000000, 32'h7F800000};
        vecs[5]  = '{32'h00800000, 32'h00800000, 32'h00000000};
        vecs[6]  = '{32'h80400000, 32'h3F800000, 32'h80000000};
        vecs[7]  = '{32'h7F800000, 32'h00000000, 32'h7FC00000};
        vecs[8]  = '{32'hFF800000, 32'h40000000, 32'hFF800000};
        vecs[9]  = '{32'h7FC00001, 32'h3F800000, 32'h7FC00000};
        vecs[10] = '{32'h40000000, 32'h40400000, 32'h40C00000};
        vecs[11] = '{32'hBF800000, 32'hBF800000, 32'h3F800000};
        vecs[12] = '{32'h3F000000, 32'h3F000000, 32'h3E800000};
        vecs[13] = '{32'h00000001, 32'hFF800000, 32'h7FC00000};

        bus.run     = 1'b0;
        bus.running = 1'b0;
        bus.in0     = 32'h0;
        bus.in1     = 32'h0;

        // Reset state.
        #1;
        check_val("reset", -1, bus.out0, 32'h0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        check_val("reset_hold", -1, bus.out0, 32'h0);

        // Table vectors back to back, then drain with 0 x 0.
        for (int i = 0; i < NVEC; i++)
            step(1'b1, (i == 0), i, vecs[i].a, vecs[i].b, vecs[i].y, "vec");
        for (int i = 0; i < 3; i++)
            step(1'b1, 1'b0, 100 + i, 32'h0, 32'h0, 32'h0, "drain");

        // Streaming with a 5-cycle stall mid-stream; garbage on the inputs
        // while stalled must not enter the pipe.
        for (int i = 0; i < 8; i++) begin
            if (i == 4) begin
                for (int s = 0; s < 5; s++)
                    step(1'b0, (s == 2), -2, $urandom, $urandom, 32'h0, "stall");
            end
            step(1'b1, 1'b0, 200 + i, vecs[i].a, vecs[i].b, vecs[i].y, "stream");
        end
        for (int i = 0; i < 3; i++)
            step(1'b1, 1'b0, 300 + i, 32'h0, 32'h0, 32'h0, "drain");

        // Asynchronous reset with pairs in flight; out0 is non-zero first.
        step(1'b1, 1'b0, 400, vecs[10].a, vecs[10].b, vecs[10].y, "pre_rst");
        step(1'b1, 1'b0, 401, vecs[1].a,  vecs[1].b,  vecs[1].y,  "pre_rst");
        step(1'b1, 1'b0, 402, vecs[8].a,  vecs[8].b,  vecs[8].y,  "pre_rst");
        #2;
        rst = 1'b1;
        #1;
        sb_q.delete();
        cur_exp = 32'h0;
        cur_tag = -3;
        check_val("async_rst", cur_tag, bus.out0, 32'h0);
        bus.running = 1'b1;
        @(posedge clk);
        #1;
        check_val("rst_edge", cur_tag, bus.out0, 32'h0);
        rst = 1'b0;

        // Refill: zeros until the third running edge after new operands.
        step(1'b1, 1'b1, 500, vecs[0].a,  vecs[0].b,  vecs[0].y,  "refill");
        step(1'b1, 1'b0, 501, vecs[3].a,  vecs[3].b,  vecs[3].y,  "refill");
        step(1'b1, 1'b0, 502, vecs[12].a, vecs[12].b, vecs[12].y, "refill");
        for (int i = 0; i < 3; i++)
            step(1'b1, 1'b0, 503 + i, 32'h0, 32'h0, 32'h0, "drain");

        if (sb_q.size() > 2) begin
            n_fail++;
            $display("FAIL scoreboard_leftover entries=%0d expected<=2", sb_q.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
        $finish;
    end

endmodule
